// File: rtl/snoop_packer_pkg.sv
// Shared definitions for the snooper write-side adapter: state encodings and
// byte-enable helpers for MSB-first 32-bit beats.
package snoop_packer_pkg;

    localparam logic [1:0] SNP_IDLE   = 2'd0;
    localparam logic [1:0] SNP_STREAM = 2'd1;
    localparam logic [1:0] SNP_FLUSH  = 2'd2;
    localparam logic [1:0] SNP_DONE   = 2'd3;

    function automatic logic [2:0] keep_bytes(input logic [3:0] keep);
        return {2'b00, keep[3]} + {2'b00, keep[2]} + {2'b00, keep[1]} + {2'b00, keep[0]};
    endfunction

    function automatic logic [31:0] keep_mask(input logic [3:0] keep);
        return {{8{keep[3]}}, {8{keep[2]}}, {8{keep[1]}}, {8{keep[0]}}};
    endfunction

endpackage

// File: rtl/snoop_word_accum.sv
// Packs 32-bit beats MSB-first into DATA_WIDTH-bit words; flags a word as ready
// when full or when the last beat leaves bytes pending.
module snoop_word_accum
    import snoop_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  beat_vld,
    input  logic [31:0]           beat_data,
    input  logic [3:0]            beat_keep,
    input  logic                  beat_last,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_rdy
);

    localparam int BEATS = DATA_WIDTH / 32;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    logic [DATA_WIDTH-1:0] acc;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            eff_keep;
    logic [31:0]           masked;

    assign eff_keep = beat_last ? beat_keep : 4'hF;
    assign masked   = beat_data & keep_mask(eff_keep);

    // Slot-indexed placement is equivalent to an MSB-first shift, since only the
    // final beat may be partial and trailing slots stay zero.
    always_comb begin
        word = acc;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (idx == IDX_W'(i))
                word[DATA_WIDTH-1-32*i -: 32] = masked;
        end
    end

    assign word_rdy = beat_vld &&
                      ((idx == LAST_IDX) || (beat_last && ((idx != '0) || (|beat_keep))));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
            idx <= '0;
        end else if (beat_vld) begin
            if (word_rdy || beat_last) begin
                acc <= '0;
                idx <= '0;
            end else begin
                acc <= word;
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/snoop_packer.sv
// Write-side adapter: claims a ping-pong buffer, packs the snooped byte stream into
// memory words at sequential addresses, and reports the stored packet length.
module snoop_packer
    import snoop_packer_pkg::*;
#(
    parameter int BYTE_ADDR_WIDTH = 12,
    parameter int ADDR_WIDTH      = 9,
    parameter int DATA_WIDTH      = 2 ** (BYTE_ADDR_WIDTH - ADDR_WIDTH) * 8,
    parameter int PLEN_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           sn_data,
    input  logic                  sn_vld,
    input  logic                  sn_last,
    input  logic [3:0]            sn_keep,
    output logic                  sn_rdy,
    input  logic                  rdy_for_sn,
    output logic                  rdy_for_sn_ack,
    output logic                  done,
    input  logic                  done_ack,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [PLEN_WIDTH-1:0] byte_len
);

    localparam logic [PLEN_WIDTH-1:0] CAP = PLEN_WIDTH'(1) << BYTE_ADDR_WIDTH;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  full;
    logic                  accept;
    logic [3:0]            eff_keep;
    logic [PLEN_WIDTH-1:0] len_sum;
    logic [PLEN_WIDTH-1:0] len_nxt;
    logic [DATA_WIDTH-1:0] word;
    logic                  word_rdy;

    assign sn_rdy         = (state == SNP_STREAM);
    assign done           = (state == SNP_DONE);
    assign rdy_for_sn_ack = !rst && (state == SNP_IDLE) && rdy_for_sn;
    assign accept         = sn_vld && sn_rdy;
    assign eff_keep       = sn_last ? sn_keep : 4'hF;

    always_comb begin
        len_sum = byte_len + PLEN_WIDTH'(keep_bytes(eff_keep));
        len_nxt = (len_sum > CAP) ? CAP : len_sum;
    end

    snoop_word_accum #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_accum (
        .clk       (clk),
        .rst       (rst),
        .clear     (rdy_for_sn_ack),
        .beat_vld  (accept),
        .beat_data (sn_data),
        .beat_keep (sn_keep),
        .beat_last (sn_last),
        .word      (word),
        .word_rdy  (word_rdy)
    );

    // Once the top word address has been written the buffer is full: later
    // words are dropped and the address register holds rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SNP_IDLE;
            addr     <= '0;
            full     <= 1'b0;
            byte_len <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                SNP_IDLE: begin
                    if (rdy_for_sn_ack) begin
                        state    <= SNP_STREAM;
                        addr     <= '0;
                        full     <= 1'b0;
                        byte_len <= '0;
                    end
                end
                SNP_STREAM: begin
                    if (accept) begin
                        byte_len <= len_nxt;
                        if (word_rdy && !full) begin
                            wr_en   <= 1'b1;
                            wr_addr <= addr;
                            wr_data <= word;
                            if (addr == '1)
                                full <= 1'b1;
                            else
                                addr <= addr + 1'b1;
                        end
                        if (sn_last)
                            state <= SNP_FLUSH;
                    end
                end
                SNP_FLUSH: state <= SNP_DONE;
                SNP_DONE: begin
                    if (done_ack)
                        state <= SNP_IDLE;
                end
                default: state <= SNP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_packer.sv
// Directed bench for snoop_packer at default parameters (64-bit words, 4 KiB buffer).
module tb_snoop_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sn_data = '0;
    logic        sn_vld = 1'b0;
    logic        sn_last = 1'b0;
    logic [3:0]  sn_keep = '0;
    logic        sn_rdy;
    logic        rdy_for_sn = 1'b0;
    logic        rdy_for_sn_ack;
    logic        done;
    logic        done_ack = 1'b0;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [63:0] wr_data;
    logic [31:0] byte_len;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned rdy_miss = 0;
    logic [8:0]  wq_addr[$];
    logic [63:0] wq_data[$];

    snoop_packer dut (
        .clk            (clk),
        .rst            (rst),
        .sn_data        (sn_data),
        .sn_vld         (sn_vld),
        .sn_last        (sn_last),
        .sn_keep        (sn_keep),
        .sn_rdy         (sn_rdy),
        .rdy_for_sn     (rdy_for_sn),
        .rdy_for_sn_ack (rdy_for_sn_ack),
        .done           (done),
        .done_ack       (done_ack),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .byte_len       (byte_len)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic claim();
        int unsigned n = 0;
        wq_addr.delete();
        wq_data.delete();
        rdy_miss = 0;
        @(posedge clk); #1;
        rdy_for_sn = 1'b1;
        @(negedge clk);
        while (!rdy_for_sn_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("claim_ack", 64'(rdy_for_sn_ack), 64'(1));
        check("claim_rdy_lo", 64'(sn_rdy), 64'(0));
        @(posedge clk); #1;
        rdy_for_sn = 1'b0;
        check("ack_pulse_end", 64'(rdy_for_sn_ack), 64'(0));
    endtask

    task automatic beat(input logic [31:0] d, input logic last, input logic [3:0] keep);
        sn_vld  = 1'b1;
        sn_data = d;
        sn_last = last;
        sn_keep = keep;
        @(negedge clk);
        if (!sn_rdy) rdy_miss++;
        @(posedge clk); #1;
        sn_vld  = 1'b0;
        sn_last = 1'b0;
        sn_keep = '0;
    endtask

    task automatic finish_pkt(input logic [31:0] exp_len, input int unsigned ack_delay);
        int unsigned drops = 0;
        check("stream_rdy", 64'(rdy_miss), 64'(0));
        @(negedge clk);
        check("flush_done", 64'(done), 64'(0));
        check("flush_rdy", 64'(sn_rdy), 64'(0));
        @(negedge clk);
        check("done_hi", 64'(done), 64'(1));
        check("byte_len", 64'(byte_len), 64'(exp_len));
        for (int unsigned i = 0; i < ack_delay; i++) begin
            @(negedge clk);
            if (!done) drops++;
        end
        if (ack_delay != 0) check("done_held", 64'(drops), 64'(0));
        @(posedge clk); #1;
        done_ack   = 1'b1;
        rdy_for_sn = 1'b1;
        @(negedge clk);
        check("done_in_ack", 64'(done), 64'(1));
        check("ack_ignored", 64'(rdy_for_sn_ack), 64'(0));
        @(posedge clk); #1;
        done_ack   = 1'b0;
        rdy_for_sn = 1'b0;
        @(negedge clk);
        check("done_dropped", 64'(done), 64'(0));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_sn_rdy"}, 64'(sn_rdy), 64'(0));
        check({tag, "_ack"}, 64'(rdy_for_sn_ack), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_wr_en"}, 64'(wr_en), 64'(0));
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'(0));
        check({tag, "_wr_data"}, wr_data, 64'(0));
        check({tag, "_byte_len"}, 64'(byte_len), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned hi_cnt;
        int unsigned derr;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");

        hi_cnt = 0;
        for (int unsigned i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sn_rdy) hi_cnt++;
        end
        check("idle_no_rdy", 64'(hi_cnt), 64'(0));

        // two full beats -> one word
        claim();
        beat(32'h01020304, 1'b0, 4'hF);
        beat(32'h05060708, 1'b1, 4'hF);
        finish_pkt(32'd8, 5);
        check("p1_nwr", 64'(wq_addr.size()), 64'(1));
        check("p1_addr", 64'(wq_addr[0]), 64'(0));
        check("p1_data", wq_data[0], 64'h0102030405060708);

        // partial last beat, zero padded
        claim();
        beat(32'hAABBCCDD, 1'b0, 4'hF);
        beat(32'hEEFF1234, 1'b1, 4'hC);
        finish_pkt(32'd6, 0);
        check("p2_nwr", 64'(wq_addr.size()), 64'(1));
        check("p2_data", wq_data[0], 64'hAABBCCDDEEFF0000);

        // three beats -> two words
        claim();
        beat(32'h11111111, 1'b0, 4'hF);
        beat(32'h22222222, 1'b0, 4'hF);
        beat(32'h33333333, 1'b1, 4'hF);
        finish_pkt(32'd12, 0);
        check("p3_nwr", 64'(wq_addr.size()), 64'(2));
        check("p3_addr0", 64'(wq_addr[0]), 64'(0));
        check("p3_data0", wq_data[0], 64'h1111111122222222);
        check("p3_addr1", 64'(wq_addr[1]), 64'(1));
        check("p3_data1", wq_data[1], 64'h3333333300000000);

        // zero-length packet
        claim();
        beat(32'hDEADBEEF, 1'b1, 4'h0);
        finish_pkt(32'd0, 0);
        check("p4_nwr", 64'(wq_addr.size()), 64'(0));

        // keep ignored on a non-last beat; 3-byte last beat
        claim();
        beat(32'hA1A2A3A4, 1'b0, 4'h0);
        beat(32'hB1B2B3B4, 1'b1, 4'hE);
        finish_pkt(32'd7, 0);
        check("p5_nwr", 64'(wq_addr.size()), 64'(1));
        check("p5_data", wq_data[0], 64'hA1A2A3A4B1B2B300);

        // single one-byte packet
        claim();
        beat(32'hDE112233, 1'b1, 4'h8);
        finish_pkt(32'd1, 0);
        check("p6_data", wq_data.size() == 1 ? wq_data[0] : 64'hX, 64'hDE00000000000000);

        // overflow: 1025 beats, only 512 words fit
        claim();
        for (int unsigned i = 0; i <= 1024; i++)
            beat(i, i == 1024, 4'hF);
        check("ovf_nwr", 64'(wq_addr.size()), 64'(512));
        derr = 0;
        for (int unsigned k = 0; k < wq_addr.size() && k < 512; k++) begin
            if (wq_addr[k] !== 9'(k)) derr++;
            if (wq_data[k] !== {32'(2*k), 32'(2*k+1)}) derr++;
        end
        check("ovf_word_errs", 64'(derr), 64'(0));
        finish_pkt(32'd4096, 0);
        check("ovf_nwr_after", 64'(wq_addr.size()), 64'(512));
        check("ovf_no_wrap", 64'(wr_addr), 64'(511));

        // reset mid-packet
        claim();
        beat(32'h12345678, 1'b0, 4'hF);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("midrst");
        check("midrst_nwr", 64'(wq_addr.size()), 64'(0));

        claim();
        beat(32'hCAFEF00D, 1'b0, 4'hF);
        beat(32'h0BADBEEF, 1'b1, 4'hF);
        finish_pkt(32'd8, 0);
        check("post_nwr", 64'(wq_addr.size()), 64'(1));
        check("post_addr", 64'(wq_addr[0]), 64'(0));
        check("post_data", wq_data[0], 64'hCAFEF00D0BADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
